// File: rtl/jxli_fp8_pkg.sv
// Shared FP8 (1-4-3, bias 7) definitions for the FP8 multiplier and accumulator.
// Contents: operand struct, accumulator FSM state type, format constants and
// operand classification helpers.
package jxli_fp8_pkg;

    localparam int EXP_W = 4;           // exponent field width
    localparam int MAN_W = 3;           // stored mantissa width, hidden bit implicit
    localparam int SIG_W = MAN_W + 3;   // {1, m, G, R}

    localparam int         FP8_BIAS = 7;
    localparam logic [3:0] FP8_EMAX = 4'hF;
    localparam logic [7:0] FP8_QNAN = 8'hFF;
    localparam logic [7:0] FP8_PINF = 8'h78;
    localparam logic [7:0] FP8_NINF = 8'hF8;

    typedef struct packed {
        logic       s;
        logic [3:0] e;
        logic [2:0] m;
    } fp8_t;

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} state_t;

    // Exponent field 0 covers both zero and subnormals, which are flushed.
    function automatic logic is_zero(fp8_t x);
        return x.e == 4'h0;
    endfunction

    function automatic logic is_inf(fp8_t x);
        return (x.e == FP8_EMAX) && (x.m == 3'b000);
    endfunction

    function automatic logic is_nan(fp8_t x);
        return (x.e == FP8_EMAX) && (x.m != 3'b000);
    endfunction

endpackage

// File: rtl/jxli_fp8_lzc.sv
// Combinational 7-bit leading-zero counter for the accumulator NORM stage.
// Ports: din  - 7-bit value {carry, significand}
//        cnt  - number of leading zeros (7 when din is zero)
module jxli_fp8_lzc (
    input  logic [6:0] din,
    output logic [2:0] cnt
);

    // Scan upward so the highest set bit is the last one to write cnt.
    always_comb begin
        cnt = 3'd7;
        for (int i = 0; i < 7; i++) begin
            if (din[i]) cnt = 3'(6 - i);
        end
    end

endmodule

// File: rtl/jxli_fp8acc.sv
// Sequential FP8 accumulator: adds one operand per handshake to a running sum
// through a fixed IDLE -> ALIGN -> ADD -> NORM -> ROUND -> IDLE sequence.
// Ports: clock, reset_n (async, active low)
//        clear     - synchronous clear of the sum, aborts any add in flight
//        in_valid / in_ready / in_data - operand handshake
//        acc_out   - registered FP8 sum
//        busy      - an add is in flight
module jxli_fp8acc
    import jxli_fp8_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic [7:0] acc_out,
    output logic       busy
);

    state_t state;
    fp8_t   acc;
    fp8_t   opnd;

    // Pipeline state carried between FSM steps; sig_l is reused to hold the
    // normalised significand after NORM.
    logic              sp;        // result decided by a special case
    logic [7:0]        sp_val;
    logic              r_s;
    logic signed [5:0] r_exp;
    logic [SIG_W-1:0]  sig_l;
    logic [SIG_W-1:0]  sig_s;
    logic              stk;
    logic              eff_sub;
    logic [6:0]        sum;
    logic              r_zero;

    // ALIGN combinational signals
    fp8_t             big, sml;
    logic             swap;
    logic [3:0]       ediff;
    logic [SIG_W-1:0] sml_sig, sig_sh;
    logic             stk_sh;
    logic             al_sp;
    logic [7:0]       al_val;

    // ADD / NORM / ROUND combinational signals
    logic [6:0]        sum_c;
    logic [2:0]        lzc, sh;
    logic [SIG_W-1:0]  n_sig;
    logic              n_stk;
    logic signed [5:0] n_exp;
    logic              n_zero;
    logic              rnd_up, rnd_carry;
    logic [2:0]        m_out;
    logic signed [5:0] f_exp;
    logic [7:0]        rnd_val;

    assign in_ready = (state == IDLE) & ~clear;
    assign busy     = (state != IDLE);
    assign acc_out  = acc;

    jxli_fp8_lzc u_lzc (
        .din (sum),
        .cnt (lzc)
    );

    // ALIGN: order by magnitude and shift the smaller significand into place.
    always_comb begin
        swap    = {opnd.e, opnd.m} > {acc.e, acc.m};
        big     = swap ? opnd : acc;
        sml     = swap ? acc : opnd;
        ediff   = big.e - sml.e;
        sml_sig = {1'b1, sml.m, 2'b00};
        sig_sh  = '0;
        stk_sh  = 1'b0;
        if (ediff >= 4'd6) begin
            stk_sh = 1'b1;
        end else begin
            sig_sh = sml_sig >> ediff;
            for (int i = 0; i < SIG_W; i++) begin
                if (i < int'(ediff) && sml_sig[i]) stk_sh = 1'b1;
            end
        end

        // Zero operands pass the other side through untouched, so a cleared
        // sum plus x gives x bit-exact.
        al_sp  = 1'b1;
        al_val = acc;
        if (is_nan(acc) || is_nan(opnd))    al_val = FP8_QNAN;
        else if (is_inf(acc) && is_inf(opnd)) al_val = (acc.s != opnd.s) ? FP8_QNAN : acc;
        else if (is_inf(acc))                al_val = acc;
        else if (is_inf(opnd))               al_val = opnd;
        else if (is_zero(opnd))              al_val = acc;
        else if (is_zero(acc))               al_val = opnd;
        else                                 al_sp  = 1'b0;
    end

    // ADD / NORM / ROUND datapath.
    always_comb begin
        // A set sticky means the true small operand is slightly larger than
        // sig_s, so the subtract borrows one; the sticky stays set below R.
        sum_c = eff_sub ? ({1'b0, sig_l} - {1'b0, sig_s} - {6'b0, stk})
                        : ({1'b0, sig_l} + {1'b0, sig_s});

        sh     = lzc - 3'd1;
        n_zero = (sum == 7'd0) && !stk;
        if (sum[6]) begin
            n_sig = sum[6:1];
            n_stk = stk | sum[0];
            n_exp = r_exp + 6'sd1;
        end else begin
            n_sig = 6'(sum << sh);
            n_stk = stk;
            n_exp = r_exp - $signed({3'b000, sh});
        end

        // Round to nearest even on G with R|S as the tie breaker.
        rnd_up    = sig_l[1] & (sig_l[0] | stk | sig_l[2]);
        rnd_carry = rnd_up & (&sig_l[4:2]);
        m_out     = 3'(sig_l[4:2] + {2'b00, rnd_up});
        f_exp     = rnd_carry ? r_exp + 6'sd1 : r_exp;
        if (sp)                    rnd_val = sp_val;
        else if (r_zero)           rnd_val = 8'h00;
        else if (f_exp >= 6'sd15)  rnd_val = r_s ? FP8_NINF : FP8_PINF;
        else if (f_exp <= 6'sd0)   rnd_val = 8'h00;
        else                       rnd_val = {r_s, f_exp[3:0], m_out};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            acc     <= '0;
            opnd    <= '0;
            sp      <= 1'b0;
            sp_val  <= '0;
            r_s     <= 1'b0;
            r_exp   <= '0;
            sig_l   <= '0;
            sig_s   <= '0;
            stk     <= 1'b0;
            eff_sub <= 1'b0;
            sum     <= '0;
            r_zero  <= 1'b0;
        end else if (clear) begin
            state <= IDLE;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opnd  <= fp8_t'(in_data);
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    sp      <= al_sp;
                    sp_val  <= al_val;
                    r_s     <= big.s;
                    r_exp   <= $signed({2'b00, big.e});
                    sig_l   <= {1'b1, big.m, 2'b00};
                    sig_s   <= sig_sh;
                    stk     <= stk_sh;
                    eff_sub <= acc.s ^ opnd.s;
                    state   <= ADD;
                end
                ADD: begin
                    sum   <= sum_c;
                    state <= NORM;
                end
                NORM: begin
                    sig_l  <= n_sig;
                    stk    <= n_stk;
                    r_exp  <= n_exp;
                    r_zero <= n_zero;
                    state  <= ROUND;
                end
                ROUND: begin
                    acc   <= fp8_t'(rnd_val);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jxli_fp8acc.sv
module tb_jxli_fp8acc;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, busy;
    logic [7:0] acc_out;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] model_acc = 8'h00;

    jxli_fp8acc dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .acc_out  (acc_out),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---- reference model: exact value in units of 2^-9, then RNE to FP8 ----
    function automatic int fp_val(logic [7:0] x);
        int mag;
        if (x[6:3] == 4'h0) return 0;
        mag = (8 + int'(x[2:0])) << (int'(x[6:3]) - 1);
        return x[7] ? -mag : mag;
    endfunction

    function automatic logic [7:0] to_fp8(int v);
        int a, e, q, n, rem;
        logic s, up;
        if (v == 0) return 8'h00;
        s = (v < 0);
        a = s ? -v : v;
        if (a < 8) return 8'h00;                 // below the smallest normal: flush
        e = 1;
        while (a >= (16 << (e - 1))) e++;
        q   = 1 << (e - 1);
        n   = a >> (e - 1);
        rem = a - n * q;
        up  = (e > 1) && ((rem > q / 2) || ((rem == q / 2) && (n % 2 == 1)));
        n   = n + int'(up);
        if (n == 16) begin n = 8; e++; end
        if (e >= 15) return {s, 4'hF, 3'b000};
        return {s, 4'(e), 3'(n - 8)};
    endfunction

    function automatic logic is_nan_b(logic [7:0] x); return x[6:3] == 4'hF && x[2:0] != 0; endfunction
    function automatic logic is_inf_b(logic [7:0] x); return x[6:3] == 4'hF && x[2:0] == 0; endfunction
    function automatic logic is_zero_b(logic [7:0] x); return x[6:3] == 4'h0; endfunction

    function automatic logic [7:0] ref_add(logic [7:0] a, logic [7:0] b);
        if (is_nan_b(a) || is_nan_b(b)) return 8'hFF;
        if (is_inf_b(a) && is_inf_b(b)) return (a[7] != b[7]) ? 8'hFF : a;
        if (is_inf_b(a)) return a;
        if (is_inf_b(b)) return b;
        if (is_zero_b(b)) return a;
        if (is_zero_b(a)) return b;
        return to_fp8(fp_val(a) + fp_val(b));
    endfunction

    // One full add: waits for in_ready, then checks latency and result.
    task automatic add_op(input logic [7:0] op);
        logic [7:0] prev;
        int guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clock); #1;
            guard++;
        end
        check("ready_before_accept", {7'b0, in_ready}, 8'h01);
        prev     = model_acc;
        in_valid = 1'b1;
        in_data  = op;
        @(posedge clock); #1;
        in_valid  = 1'b0;
        model_acc = ref_add(model_acc, op);
        check("busy_after_accept", {7'b0, busy}, 8'h01);
        check("ready_low_busy", {7'b0, in_ready}, 8'h00);
        repeat (3) begin @(posedge clock); #1; end
        check("acc_held_t3", acc_out, prev);
        @(posedge clock); #1;
        check("acc_at_t4", acc_out, model_acc);
        check("idle_at_t4", {7'b0, busy}, 8'h00);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clock); #1;
        clear     = 1'b0;
        model_acc = 8'h00;
        check("clear_sum", acc_out, 8'h00);
        check("clear_idle", {7'b0, busy}, 8'h00);
    endtask

    logic [7:0] op;
    int         n_acc, last_edge, gap_ok, guard;
    logic       rdy;

    initial begin
        // reset
        repeat (2) @(posedge clock);
        #1;
        check("reset_acc", acc_out, 8'h00);
        check("reset_busy", {7'b0, busy}, 8'h00);
        reset_n = 1'b1;
        #1;
        check("reset_ready", {7'b0, in_ready}, 8'h01);

        // reset mid-add drops the operand and the sum
        add_op(8'h38);
        in_valid = 1'b1; in_data = 8'h44;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        check("rst_mid_acc", acc_out, 8'h00);
        check("rst_mid_busy", {7'b0, busy}, 8'h00);
        check("rst_mid_ready", {7'b0, in_ready}, 8'h01);
        @(posedge clock); #1;
        reset_n   = 1'b1;
        model_acc = 8'h00;
        @(posedge clock); #1;
        check("rst_mid_after", acc_out, 8'h00);

        // -60 + 3 = -57 -> -56
        add_op(8'hE7);
        check("vec_e7", acc_out, 8'hE7);
        add_op(8'h44);
        check("vec_e6", acc_out, 8'hE6);

        // ties to even
        do_clear();
        add_op(8'h39);
        add_op(8'h18);
        check("tie_up", acc_out, 8'h3A);
        do_clear();
        add_op(8'h38);
        add_op(8'h18);
        check("tie_down", acc_out, 8'h38);

        // overflow, cancellation, underflow flush
        do_clear();
        add_op(8'h77);
        add_op(8'h77);
        check("overflow_inf", acc_out, 8'h78);
        do_clear();
        add_op(8'h44);
        add_op(8'hC4);
        check("cancel_zero", acc_out, 8'h00);
        do_clear();
        add_op(8'h08);
        add_op(8'h89);
        check("underflow_flush", acc_out, 8'h00);

        // specials
        do_clear();
        add_op(8'h78);
        add_op(8'hF8);
        check("inf_minus_inf", acc_out, 8'hFF);
        do_clear();
        add_op(8'h7A);
        check("nan_in", acc_out, 8'hFF);
        add_op(8'h38);
        check("nan_sticky", acc_out, 8'hFF);
        do_clear();

        // clear beats a same-cycle operand
        clear = 1'b1; in_valid = 1'b1; in_data = 8'h38;
        #1;
        check("clear_ready_low", {7'b0, in_ready}, 8'h00);
        @(posedge clock); #1;
        clear = 1'b0; in_valid = 1'b0;
        check("clear_drop_busy", {7'b0, busy}, 8'h00);
        check("clear_drop_acc", acc_out, 8'h00);

        // clear during ROUND discards the in-flight result
        add_op(8'h44);
        in_valid = 1'b1; in_data = 8'h44;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        check("in_round_busy", {7'b0, busy}, 8'h01);
        do_clear();
        repeat (2) begin @(posedge clock); #1; end
        check("round_clear_held", acc_out, 8'h00);

        // in_valid held with a constant operand across 11 edges
        in_valid = 1'b1; in_data = 8'h38;
        n_acc = 0; last_edge = -100; gap_ok = 1;
        for (int c = 0; c < 11; c++) begin
            rdy = in_ready;
            @(posedge clock); #1;
            if (rdy) begin
                n_acc++;
                if (c - last_edge < 4) gap_ok = 0;
                last_edge = c;
                model_acc = ref_add(model_acc, 8'h38);
            end
            if (busy && in_ready) gap_ok = 0;
        end
        in_valid = 1'b0;
        guard = 0;
        while (busy && guard < 20) begin @(posedge clock); #1; guard++; end
        check("hold_idle", {7'b0, busy}, 8'h00);
        check("hold_accepts", 8'(n_acc), 8'd3);
        check("hold_spacing", 8'(gap_ok), 8'd1);
        check("hold_sum", acc_out, model_acc);
        check("hold_sum_3", acc_out, 8'h44);

        // randomized sequence against the model
        for (int i = 0; i < 60; i++) begin
            if (i % 8 == 0) do_clear();
            if ($urandom_range(0, 15) == 0) op = 8'($urandom);
            else op = {1'($urandom), 4'($urandom_range(1, 14)), 3'($urandom)};
            add_op(op);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
